dm_responder: RTL
=================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEPTH_WORDS, 1024, number of 32-bit words in the data store.
- LATENCY, 2, edges spent in BUSY, legal range 1..15.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  pipeline presents a memory request.
- req_ready  output  1  responder can accept a request.
- req_we  input  4  byte-lane write enables; 0000 means a load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, lane-aligned.
- req_pc  input  32  PC of the requesting instruction, used for the write log.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  pipeline consumes the response.
- rsp_rdata  output  32  word read back.
- rsp_err  output  1  address was out of range.
- busy  output  1  freeze request to the pipeline.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE.
REQ-005 busy SHALL equal (state != IDLE), decoded combinationally from the state register.
REQ-006 Accept: at an edge where req_valid=1 and req_ready=1, the block SHALL latch req_we, req_addr, req_wdata and req_pc, enter BUSY and load cnt with LATENCY-1.
REQ-007 In BUSY, each edge SHALL decrement cnt while cnt is nonzero. At the edge where cnt=0, the block SHALL commit the access and enter RESP.
REQ-008 Latency: with accept at edge E0, rsp_valid SHALL first be 1 in the cycle after edge E(LATENCY).
REQ-009 Word index SHALL be addr[11:2]; addr[1:0] SHALL be ignored, with no alignment fault.
REQ-010 An address SHALL be out of range when addr[31:2] >= DEPTH_WORDS. On out-of-range access:
- no write occurs;
- rsp_rdata SHALL be 0;
- rsp_err SHALL be 1.
REQ-011 Commit SHALL update each byte lane i (bits 8i+7:8i) with req_wdata lane i when we[i]=1; all other lanes SHALL be kept.
REQ-012 rsp_rdata SHALL be the stored word after the merge, so a store returns the new word and a load returns the current word.
REQ-013 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL stay stable until an edge with rsp_ready=1. At that edge the block SHALL return to IDLE.
REQ-014 No request SHALL be accepted in RESP, even if rsp_ready and req_valid are both 1. The earliest next accept is the edge after the return to IDLE.
REQ-015 Outside RESP, rsp_valid SHALL be 0. rsp_rdata and rsp_err SHALL hold their last values.
REQ-016 Dropping req_valid while in IDLE without an accept SHALL have no effect.
REQ-017 In simulation, each in-range write commit SHALL print "<time>@<pc>: *<word-aligned addr> <= <merged word>" in hex. Loads and out-of-range accesses SHALL print nothing.

Reset
REQ-018 reset=0 SHALL immediately, without waiting for clk, set:
- state to IDLE and cnt to 0;
- rsp_valid, rsp_rdata and rsp_err to 0;
- every memory word to 0.
Outputs after reset SHALL therefore be req_ready=1, busy=0.
REQ-019 Reset asserted in BUSY or RESP SHALL discard the pending request. No write SHALL occur and no response SHALL be issued.
REQ-020 Release of reset SHALL take effect at the first rising edge with reset=1. No accept SHALL occur while reset=0.

Verification
REQ-021 Store then load, LATENCY=2:
- store we=1111, addr 0x00000010, wdata 0xDEADBEEF, pc 0x3000;
- then load from 0x10;
- required: each response is first valid 2 edges after its accept, the load returns 0xDEADBEEF, and the log prints @00003000: *00000010 <= deadbeef.
REQ-022 Byte merge:
- word 0x4 holds 0x11223344;
- store we=0101, wdata 0xAABBCCDD;
- required: rsp_rdata=0x11BB33DD.
REQ-023 Backpressure: hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 throughout. Required:
- rsp_valid and rsp_rdata stay stable;
- req_ready=0 and busy=1 throughout;
- the next accept occurs exactly 2 edges after rsp_ready rises.
REQ-024 Out of range: store to addr 0x00001000 with DEPTH_WORDS=1024. Required:
- rsp_err=1 and rsp_rdata=0;
- no log line;
- word 0 unchanged.
REQ-025 Reset mid-BUSY: assert reset one cycle after accepting a store of 0x12345678 to 0x8. Required:
- outputs return to reset values without a clock edge;
- a later load from 0x8 returns 0.
REQ-026 LATENCY=1 with back-to-back loads: required response valid the cycle after edge E1 and one accept every 3 edges with rsp_ready tied to 1.

Source files
------------

// File: rtl/dm_responder.sv
// Purpose: single-port data-memory responder; accepts one request, waits LATENCY edges, answers once.
// Ports  : clk/reset (async active-low); req_* valid/ready request channel; rsp_* valid/ready response; busy = freeze.
// Latency: response valid the cycle after edge E(LATENCY); RESP holds until rsp_ready, no new accept in RESP.
module dm_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [3:0]  we_q;
   logic [29:0] word_q;     // addr[31:2]; byte offset is dropped on purpose
   logic [31:0] wdata_q;
   logic [31:0] pc_q;
   logic [31:0] mem [DEPTH_WORDS];

   logic          in_range;
   logic [AW-1:0] idx;
   logic [31:0]   merged;
   logic          unused_addr_lsb;

   // Sub-word offsets never fault; they are simply not part of the word index.
   assign unused_addr_lsb = ^req_addr[1:0];

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Range test uses the full word address so aliases above the store are caught.
   assign in_range = ({2'b00, word_q} < 32'(DEPTH_WORDS));
   assign idx      = word_q[AW-1:0];

   // Byte-lane merge of the latched store data into the addressed word.
   // With we_q == 0 this is just the current word, so loads share the path.
   always_comb begin
      merged = mem[idx];
      for (int i = 0; i < 4; i++) begin
         if (we_q[i]) begin
            merged[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= '0;
         word_q    <= '0;
         wdata_q   <= '0;
         pc_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  word_q  <= req_addr[31:2];
                  wdata_q <= req_wdata;
                  pc_q    <= req_pc;
                  cnt     <= 4'(LATENCY - 1);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Commit edge: memory and response registers update together.
                  if (in_range) begin
                     mem[idx]  <= merged;
                     rsp_rdata <= merged;
                     rsp_err   <= 1'b0;
                  end else begin
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b1;
                  end
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               // Leaving RESP goes through IDLE; req_valid is ignored here.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // Write log: one line per in-range store commit, showing the merged word.
   always @(posedge clk) begin
      if (reset && state == BUSY && cnt == 4'd0 && in_range && we_q != 4'd0) begin
         $display("%0t@%08h: *%08h <= %08h", $time, pc_q, {word_q, 2'b00}, merged);
      end
   end
`endif

endmodule
